// File: rtl/hilo_op_if.sv
// Request handshake between the CPU control FSM and the HI/LO sequencer.
// The requester drives the operation; the sequencer answers with op_ready.
interface hilo_op_if;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ready;

    modport master (
        output op_valid,
        output op_code,
        output op_a,
        output op_b,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_code,
        input  op_a,
        input  op_b,
        output op_ready
    );
endinterface

// File: rtl/hilo_seq_ctrl.sv
// Sequences the multi-cycle divide/multiply cores and owns the HI/LO registers.
// Handles divide-by-zero, core timeout and abort of an in-flight operation.
module hilo_seq_ctrl #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clk,
    input  logic        reset,
    hilo_op_if.slave    op,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic        timeout_err,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        div_go,
    input  logic        div_done,
    input  logic [31:0] div_hi_in,
    input  logic [31:0] div_lo_in,
    output logic        mul_go,
    input  logic        mul_done,
    input  logic [31:0] mul_hi_in,
    input  logic [31:0] mul_lo_in
);

    localparam logic [2:0]       OP_MULT  = 3'd1;
    localparam logic [2:0]       OP_DIV   = 3'd2;
    localparam logic [2:0]       OP_MTHI  = 3'd3;
    localparam logic [2:0]       OP_MTLO  = 3'd4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        MUL_RUN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    state_t            state_reg,  state_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic [31:0]       hi_reg,     hi_next;
    logic [31:0]       lo_reg,     lo_next;
    logic [31:0]       core_a_reg, core_a_next;
    logic [31:0]       core_b_reg, core_b_next;
    logic              done_reg,   done_next;
    logic              dz_reg,     dz_next;
    logic              to_reg,     to_next;

    logic              accept;
    logic              div_sel;
    logic              core_done;
    logic [31:0]       res_hi;
    logic [31:0]       res_lo;

    assign accept  = op.op_valid && (state_reg == IDLE);
    assign div_sel = (state_reg == DIV_RUN);

    // Completion is only honoured from the core that is currently running.
    always_comb begin
        core_done = 1'b0;
        if (state_reg == DIV_RUN) begin
            core_done = div_done;
        end else if (state_reg == MUL_RUN) begin
            core_done = mul_done;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_res_mux
            assign res_hi[gi] = div_sel ? div_hi_in[gi] : mul_hi_in[gi];
            assign res_lo[gi] = div_sel ? div_lo_in[gi] : mul_lo_in[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            core_a_reg <= '0;
            core_b_reg <= '0;
            done_reg   <= 1'b0;
            dz_reg     <= 1'b0;
            to_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            core_a_reg <= core_a_next;
            core_b_reg <= core_b_next;
            done_reg   <= done_next;
            dz_reg     <= dz_next;
            to_reg     <= to_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        core_a_next = core_a_reg;
        core_b_next = core_b_reg;
        done_next   = 1'b0;
        dz_next     = 1'b0;
        to_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    core_a_next = op.op_a;
                    core_b_next = op.op_b;
                    case (op.op_code)
                        OP_MULT: begin
                            state_next = MUL_RUN;
                            cnt_next   = '0;
                        end
                        OP_DIV: begin
                            // A zero divisor is reported without ever starting the divider.
                            if (op.op_b == 32'd0) begin
                                dz_next = 1'b1;
                            end else begin
                                state_next = DIV_RUN;
                                cnt_next   = '0;
                            end
                        end
                        OP_MTHI: begin
                            hi_next   = op.op_a;
                            done_next = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_next   = op.op_a;
                            done_next = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            DIV_RUN, MUL_RUN: begin
                cnt_next = cnt_reg + CNT_ONE;
                if (abort) begin
                    state_next = IDLE;
                end else if (core_done) begin
                    hi_next    = res_hi;
                    lo_next    = res_lo;
                    done_next  = 1'b1;
                    state_next = COMMIT;
                end else if (cnt_reg == CNT_LAST) begin
                    to_next    = 1'b1;
                    state_next = IDLE;
                end
            end

            COMMIT: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign op.op_ready   = (state_reg == IDLE);
    assign busy          = (state_reg != IDLE);
    assign div_go        = (state_reg == DIV_RUN);
    assign mul_go        = (state_reg == MUL_RUN);
    assign done          = done_reg;
    assign div_zero_exc  = dz_reg;
    assign timeout_err   = to_reg;
    assign hi_out        = hi_reg;
    assign lo_out        = lo_reg;
    assign core_a        = core_a_reg;
    assign core_b        = core_b_reg;

endmodule

// File: tb/tb_hilo_seq_ctrl.sv
// Self-checking bench for hilo_seq_ctrl: directed cases plus randomized operations
// checked against a transaction-level timeline model of the sequencer.
module tb_hilo_seq_ctrl;

    localparam int TIMEOUT = 40;
    localparam int CNT_W   = 6;
    localparam int NEVER   = 1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        abort;
    logic        busy;
    logic        done;
    logic        div_zero_exc;
    logic        timeout_err;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        div_go;
    logic        div_done;
    logic [31:0] div_hi_in;
    logic [31:0] div_lo_in;
    logic        mul_go;
    logic        mul_done;
    logic [31:0] mul_hi_in;
    logic [31:0] mul_lo_in;

    hilo_op_if op_bus ();

    hilo_seq_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .op           (op_bus),
        .abort        (abort),
        .busy         (busy),
        .done         (done),
        .div_zero_exc (div_zero_exc),
        .timeout_err  (timeout_err),
        .hi_out       (hi_out),
        .lo_out       (lo_out),
        .core_a       (core_a),
        .core_b       (core_b),
        .div_go       (div_go),
        .div_done     (div_done),
        .div_hi_in    (div_hi_in),
        .div_lo_in    (div_lo_in),
        .mul_go       (mul_go),
        .mul_done     (mul_done),
        .mul_hi_in    (mul_hi_in),
        .mul_lo_in    (mul_lo_in)
    );

    always #5 clk = ~clk;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Architectural model: HI/LO, latched operands, and pulses due in the coming cycle.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  exp_pulse;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // st = {op_ready, busy, div_go, mul_go}; pulses = {done, div_zero_exc, timeout_err}
    task automatic check_cycle(input string tag, input logic [3:0] st, input logic [2:0] pulses);
        @(negedge clk);
        check_eq({tag, "/status"},
                 64'({op_bus.op_ready, busy, div_go, mul_go, done, div_zero_exc, timeout_err}),
                 64'({st, pulses}));
        check_eq({tag, "/hi"}, 64'(hi_out), 64'(m_hi));
        check_eq({tag, "/lo"}, 64'(lo_out), 64'(m_lo));
    endtask

    task automatic drive_defaults();
        reset           = 1'b0;
        abort           = 1'b0;
        op_bus.op_valid = 1'b0;
        op_bus.op_code  = 3'($urandom);
        op_bus.op_a     = $urandom;
        op_bus.op_b     = $urandom;
        div_done        = 1'($urandom);
        mul_done        = 1'($urandom);
        div_hi_in       = $urandom;
        div_lo_in       = $urandom;
        mul_hi_in       = $urandom;
        mul_lo_in       = $urandom;
    endtask

    // Idle cycle: stray core done, abort and NOP requests must all be ignored.
    task automatic idle_cycle();
        int n;
        @(posedge clk); #1;
        drive_defaults();
        abort = 1'($urandom);
        if ($urandom_range(0, 2) == 0) begin
            n = $urandom_range(0, 3);
            op_bus.op_valid = 1'b1;
            op_bus.op_code  = (n == 0) ? 3'd0 : 3'(n + 4);
        end
        check_cycle("idle", 4'b1000, exp_pulse);
        exp_pulse = 3'b000;
    endtask

    // One operation: lat = go cycle in which the selected core reports done (0 = never),
    // abort_cyc / rst_cyc = go cycle in which abort / reset is raised (0 = never).
    task automatic do_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [31:0] rhi, input logic [31:0] rlo,
                         input int abort_cyc, input int rst_cyc);
        bit    is_div;
        bit    is_run;
        int    lat_e;
        int    ab_e;
        int    rs_e;
        int    run_len;
        string outcome;
        is_div = (code == 3'd2) && (b != 32'd0);
        is_run = is_div || (code == 3'd1);

        @(posedge clk); #1;
        drive_defaults();
        abort           = 1'($urandom);
        op_bus.op_valid = 1'b1;
        op_bus.op_code  = code;
        op_bus.op_a     = a;
        op_bus.op_b     = b;
        check_cycle("accept", 4'b1000, exp_pulse);
        exp_pulse = 3'b000;
        m_a       = a;
        m_b       = b;
        outcome   = "nop";
        case (code)
            3'd2: if (b == 32'd0) begin exp_pulse = 3'b010; outcome = "div_zero"; end
            3'd3: begin m_hi = a; exp_pulse = 3'b100; outcome = "mthi"; end
            3'd4: begin m_lo = a; exp_pulse = 3'b100; outcome = "mtlo"; end
            default: ;
        endcase

        if (is_run) begin
            lat_e   = (lat == 0) ? NEVER : lat;
            ab_e    = (abort_cyc == 0) ? NEVER : abort_cyc;
            rs_e    = (rst_cyc == 0) ? NEVER : rst_cyc;
            run_len = TIMEOUT;
            if (lat_e < run_len) run_len = lat_e;
            if (ab_e < run_len)  run_len = ab_e;
            if (rs_e < run_len)  run_len = rs_e;

            for (int k = 1; k <= run_len; k++) begin
                @(posedge clk); #1;
                drive_defaults();
                op_bus.op_valid = 1'($urandom);
                op_bus.op_code  = 3'd3;
                abort = (k == ab_e);
                reset = (k == rs_e);
                if (is_div) begin
                    div_done = (k == lat_e);
                    if (k == lat_e) begin div_hi_in = rhi; div_lo_in = rlo; end
                end else begin
                    mul_done = (k == lat_e);
                    if (k == lat_e) begin mul_hi_in = rhi; mul_lo_in = rlo; end
                end
                check_cycle("run", is_div ? 4'b0110 : 4'b0101, 3'b000);
                check_eq("run/core_a", 64'(core_a), 64'(m_a));
                check_eq("run/core_b", 64'(core_b), 64'(m_b));
            end

            if (rs_e == run_len) begin
                outcome = "reset";
                m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
                @(posedge clk); #1;
                drive_defaults();
                check_cycle("post_reset", 4'b1000, 3'b000);
                check_eq("post_reset/core_a", 64'(core_a), 64'(m_a));
                check_eq("post_reset/core_b", 64'(core_b), 64'(m_b));
            end else if (ab_e == run_len) begin
                outcome = "abort";
            end else if (lat_e == run_len) begin
                outcome = "commit";
                m_hi = rhi;
                m_lo = rlo;
                @(posedge clk); #1;
                drive_defaults();
                abort           = 1'($urandom);
                op_bus.op_valid = 1'($urandom);
                op_bus.op_code  = 3'd4;
                check_cycle("commit", 4'b0100, 3'b100);
            end else begin
                outcome   = "timeout";
                exp_pulse = 3'b001;
            end
        end
        $display("op code=%0d a=%08h b=%08h lat=%0d abort@%0d reset@%0d -> %s hi=%08h lo=%08h",
                 code, a, b, lat, abort_cyc, rst_cyc, outcome, m_hi, m_lo);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [2:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rl;
        int          rab;

        drive_defaults();
        reset     = 1'b1;
        m_hi      = '0;
        m_lo      = '0;
        m_a       = '0;
        m_b       = '0;
        exp_pulse = 3'b000;
        repeat (3) @(posedge clk);
        check_cycle("reset", 4'b1000, 3'b000);
        check_eq("reset/core_a", 64'(core_a), 64'(m_a));
        check_eq("reset/core_b", 64'(core_b), 64'(m_b));

        do_op(3'd3, 32'hAAAA_0001, 32'd0, 0, '0, '0, 0, 0);
        do_op(3'd4, 32'h5555_0002, 32'd0, 0, '0, '0, 0, 0);
        idle_cycle();
        do_op(3'd2, 32'd100, 32'd0, 0, '0, '0, 0, 0);
        idle_cycle();
        do_op(3'd2, 32'd100, 32'd7, 33, 32'd2, 32'd14, 0, 0);
        idle_cycle();
        do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 4, 32'd1, 32'hFFFF_FFFE, 0, 0);
        do_op(3'd2, 32'd55, 32'd3, 0, '0, '0, 0, 0);
        idle_cycle();
        do_op(3'd2, 32'd9, 32'd4, TIMEOUT, 32'd1, 32'd2, 0, 0);
        do_op(3'd1, 32'd6, 32'd7, 1, 32'd0, 32'd42, 0, 0);
        do_op(3'd2, 32'd77, 32'd5, 12, 32'hDEAD, 32'hBEEF, 12, 0);
        idle_cycle();
        do_op(3'd2, 32'd77, 32'd5, 30, 32'hDEAD, 32'hBEEF, 0, 10);
        do_op(3'd3, 32'h0000_1234, 32'd0, 0, '0, '0, 0, 0);
        do_op(3'd4, 32'h0000_5678, 32'd0, 0, '0, '0, 0, 0);
        idle_cycle();

        for (int n = 0; n < 40; n++) begin
            rc  = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rl  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TIMEOUT + 3));
            rab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, TIMEOUT)) : 0;
            do_op(rc, ra, rb, rl, $urandom, $urandom, rab, 0);
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/hilo_seq_ctrl.md
Name: hilo_seq_ctrl

Overview:
- Sequences the multi-cycle divide and multiply cores for the multicycle CPU and owns the architectural HI/LO registers.
- The main control FSM issues one operation at a time over a valid/ready handshake.
- The block latches operands, starts the selected core and waits for its completion, then commits the results to HI/LO.
- It flags divide-by-zero before ever starting the divider, times out a hung core, and supports abort on exception/flush.

Parameters:
TIMEOUT, 40, max cycles a core may hold go high before it is abandoned (must be >= 34 for the 32-bit divider)
CNT_W, 6, width of the cycle counter (2^CNT_W > TIMEOUT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op_valid  in  1  operation request
op_code  in  3  0 NOP, 1 MULT, 2 DIV, 3 MTHI, 4 MTLO, 5-7 treated as NOP
op_a  in  32  operand A (dividend / multiplicand / MTHI/MTLO data)
op_b  in  32  operand B (divisor / multiplier)
op_ready  out  1  high only in IDLE
abort  in  1  cancel in-flight operation, no commit
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on successful commit
div_zero_exc  out  1  one-cycle pulse, DIV with op_b==0
timeout_err  out  1  one-cycle pulse, core exceeded TIMEOUT
hi_out  out  32  HI register
lo_out  out  32  LO register
core_a  out  32  latched operand A to both cores
core_b  out  32  latched operand B to both cores
div_go  out  1  divider start/run level, held until div_done
div_done  in  1  divider completion, sampled only while div_go=1
div_hi_in  in  32  divider remainder
div_lo_in  in  32  divider quotient
mul_go  out  1  multiplier start/run level
mul_done  in  1  multiplier completion, sampled only while mul_go=1
mul_hi_in  in  32  product high word
mul_lo_in  in  32  product low word

Behaviour:
- Reset values:
  - All outputs 0 except op_ready=1; hi_out/lo_out/core_a/core_b = 0.
  - State IDLE, counter 0.
  - Reset mid-operation drops go the next edge and discards the result; reset has priority over everything.
- States: IDLE, DIV_RUN, MUL_RUN, COMMIT.
- Handshake: an op is accepted on an edge where op_valid && op_ready. op_a/op_b need only be stable in the accept cycle; they are latched into core_a/core_b.
- IDLE, accepted op:
  - MTHI: hi_out<=op_a; stay IDLE; done=1 the next cycle.
  - MTLO: same, writing lo_out.
  - NOP/5-7: no state change, no pulse.
  - DIV with op_b==0: div_zero_exc=1 the next cycle; HI/LO unchanged; stay IDLE; divider never started.
  - DIV with op_b!=0: go to DIV_RUN, counter<=0.
  - MULT: go to MUL_RUN, counter<=0.
- DIV_RUN / MUL_RUN:
  - The respective go is 1 in every cycle in this state, first cycle included.
  - counter increments each cycle.
  - On a cycle with done_in=1: latch hi/lo_in into hi_out/lo_out at that edge, go to COMMIT.
  - Else if counter==TIMEOUT-1: timeout_err=1 the next cycle, HI/LO unchanged, go to IDLE.
- COMMIT: done=1 for exactly this cycle, go=0, then IDLE. op_ready=0 in COMMIT, so back-to-back ops are spaced by at least one cycle.
- Latency: done asserts 1 cycle after the cycle in which core done was sampled. Each go is 0 in IDLE and COMMIT.
- Priority in a RUN state, same cycle: reset > abort > core done > timeout. Abort returns to IDLE with go low, no commit and no pulses.
- abort in IDLE or COMMIT is ignored; a COMMIT already in progress completes.
- Only one of div_go/mul_go is ever high. done_in from the non-selected core is ignored.
- Pulses done, div_zero_exc and timeout_err are mutually exclusive and never longer than 1 cycle.

Test Plan:
- DIV 100/7, div_done asserted after 33 go cycles with hi=2, lo=14 -> hi_out=2, lo_out=14, done pulse 1 cycle after div_done, busy high throughout, op_ready low until IDLE.
- DIV op_b=0 -> div_zero_exc for 1 cycle, div_go never rises, HI/LO keep prior values (preload with MTHI 0xAAAA_0001 / MTLO 0x5555_0002).
- MULT 0xFFFF_FFFF*2, mul_done after 4 cycles with hi=1, lo=0xFFFF_FFFE -> registers match; div_go stays 0.
- Divider never asserts done, TIMEOUT=40 -> timeout_err exactly 40 cycles after acceptance, div_go low afterwards, HI/LO unchanged.
- abort in the same cycle as div_done -> no commit, no done, IDLE next cycle. reset at DIV_RUN cycle 10 -> all outputs at reset values next cycle.
- MTHI 0x1234 then immediately MTLO 0x5678 -> done pulse after each; hi_out=0x1234, lo_out=0x5678.
